// File: rtl/branch_update_queue.sv
// In-order queue of in-flight branch predictions. Emits a registered BHT update
// and a mispredict pulse when the oldest branch resolves.
module branch_update_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             push_pred,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             bht_en,
    output logic [IDX_W-1:0] bht_write_addr,
    output logic             bht_was_taken,
    output logic             mispredict,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0] r_idx  [DEPTH];
    logic             r_pred [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             r_bht_en;
    logic [IDX_W-1:0] r_bht_write_addr;
    logic             r_bht_was_taken;
    logic             r_mispredict;
    logic             r_overflow_err;
    logic             r_underflow_err;

    logic             w_full;
    logic             w_empty;
    logic             w_do_resolve;
    logic             w_mis;
    logic             w_squash;
    logic             w_do_push;
    logic             w_ovf;
    logic [PTR_W-1:0] w_head_next;

    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_do_resolve = resolve_valid && !w_empty;
    assign w_mis        = w_do_resolve && (r_pred[r_head] != resolve_taken);
    // Wrong-path pushes (flush or mispredict) are silently dropped, never counted as overflow.
    assign w_squash     = flush || w_mis;
    assign w_do_push    = push_valid && !w_full && !w_squash;
    assign w_ovf        = push_valid && w_full && !w_squash;
    assign w_head_next  = w_do_resolve ? r_head + 1'b1 : r_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_bht_en         <= 1'b0;
            r_bht_write_addr <= '0;
            r_bht_was_taken  <= 1'b0;
            r_mispredict     <= 1'b0;
            r_overflow_err   <= 1'b0;
            r_underflow_err  <= 1'b0;
        end else begin
            r_bht_en     <= w_do_resolve;
            r_mispredict <= w_mis;
            if (w_do_resolve) begin
                r_bht_write_addr <= r_idx[r_head];
                r_bht_was_taken  <= resolve_taken;
            end
            if (w_ovf)
                r_overflow_err <= 1'b1;
            if (resolve_valid && w_empty)
                r_underflow_err <= 1'b1;

            r_head <= w_head_next;
            if (w_squash) begin
                r_count <= '0;
                r_tail  <= w_head_next;
            end else begin
                r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_resolve);
                if (w_do_push)
                    r_tail <= r_tail + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !rst) begin
            r_idx[r_tail]  <= push_idx;
            r_pred[r_tail] <= push_pred;
        end
    end

    assign full           = w_full;
    assign empty          = w_empty;
    assign count          = r_count;
    assign bht_en         = r_bht_en;
    assign bht_write_addr = r_bht_write_addr;
    assign bht_was_taken  = r_bht_was_taken;
    assign mispredict     = r_mispredict;
    assign overflow_err   = r_overflow_err;
    assign underflow_err  = r_underflow_err;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed self-checking bench for branch_update_queue (DEPTH=4).
module tb_branch_update_queue;

    logic       clk = 1'b0;
    logic       rst, flush, push_valid, push_pred, resolve_valid, resolve_taken;
    logic [4:0] push_idx;
    logic       full, empty, bht_en, bht_was_taken, mispredict, overflow_err, underflow_err;
    logic [2:0] count;
    logic [4:0] bht_write_addr;

    int checks = 0;
    int errors = 0;

    branch_update_queue #(.DEPTH(4), .IDX_W(5), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_idx(push_idx), .push_pred(push_pred),
        .full(full), .empty(empty), .count(count),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .bht_en(bht_en), .bht_write_addr(bht_write_addr), .bht_was_taken(bht_was_taken),
        .mispredict(mispredict), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        rst = 0; flush = 0; push_valid = 0; push_idx = '0; push_pred = 0;
        resolve_valid = 0; resolve_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] idx, input logic pred);
        idle_in(); push_valid = 1; push_idx = idx; push_pred = pred;
        tick();
    endtask

    task automatic resolve(input logic taken);
        idle_in(); resolve_valid = 1; resolve_taken = taken;
        tick();
    endtask

    task automatic upd(input string tag, input logic en, input logic [4:0] addr,
                       input logic wt, input logic mis);
        chk({tag, "_en"}, 32'(bht_en), 32'(en));
        chk({tag, "_addr"}, 32'(bht_write_addr), 32'(addr));
        chk({tag, "_wt"}, 32'(bht_was_taken), 32'(wt));
        chk({tag, "_mis"}, 32'(mispredict), 32'(mis));
    endtask

    initial begin
        idle_in(); rst = 1;
        tick(); tick();
        idle_in(); tick();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        upd("rst", 0, 0, 0, 0);
        chk("rst_ovf", 32'(overflow_err), 0);
        chk("rst_unf", 32'(underflow_err), 0);

        // Two correct resolves back to back
        push(3, 1); push(7, 0);
        chk("t2_count", 32'(count), 2);
        resolve(1);
        upd("t2_r1", 1, 3, 1, 0);
        resolve(0);
        upd("t2_r2", 1, 7, 0, 0);
        chk("t2_empty", 32'(empty), 1);
        idle_in(); tick();
        upd("t2_idle", 0, 7, 0, 0);

        // Mispredict discards younger entries
        push(4, 1); push(9, 1); push(12, 0);
        chk("t3_count", 32'(count), 3);
        resolve(0);
        upd("t3_mis", 1, 4, 0, 1);
        chk("t3_count0", 32'(count), 0);
        resolve(1);
        chk("t3_unf_en", 32'(bht_en), 0);
        chk("t3_unf_mis", 32'(mispredict), 0);
        chk("t3_unf", 32'(underflow_err), 1);

        // Fill, overflow, drain in order
        push(10, 1); push(11, 1); push(12, 1); push(13, 1);
        chk("t4_full", 32'(full), 1);
        chk("t4_count4", 32'(count), 4);
        chk("t4_ovf0", 32'(overflow_err), 0);
        push(31, 1);
        chk("t4_ovf", 32'(overflow_err), 1);
        chk("t4_count_hold", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            resolve(1);
            upd("t4_drain", 1, 5'(10 + i), 1, 0);
        end
        chk("t4_empty", 32'(empty), 1);

        // Simultaneous push + correct resolve, pointers wrap many times
        push(20, 1); push(21, 1);
        for (int i = 0; i < 8; i++) begin
            idle_in(); push_valid = 1; push_idx = 5'(5 + i); push_pred = 1;
            resolve_valid = 1; resolve_taken = 1;
            tick();
            upd("t5_pp", 1, (i == 0) ? 5'd20 : (i == 1) ? 5'd21 : 5'(i + 3), 1, 0);
            chk("t5_count", 32'(count), 2);
        end
        resolve(1);
        upd("t5_tail1", 1, 11, 1, 0);
        resolve(1);
        upd("t5_tail2", 1, 12, 1, 0);
        chk("t5_empty", 32'(empty), 1);

        // Reset mid-operation: no update on the following cycle
        push(1, 1);
        idle_in(); rst = 1; resolve_valid = 1; resolve_taken = 0;
        tick();
        chk("t6_rst_en", 32'(bht_en), 0);
        chk("t6_rst_empty", 32'(empty), 1);
        chk("t6_rst_ovf", 32'(overflow_err), 0);
        chk("t6_rst_unf", 32'(underflow_err), 0);

        // Flush + resolve + push in the same cycle
        push(6, 1); push(8, 0);
        idle_in(); flush = 1; resolve_valid = 1; resolve_taken = 1;
        push_valid = 1; push_idx = 30; push_pred = 1;
        tick();
        upd("t7_flush", 1, 6, 1, 0);
        chk("t7_count", 32'(count), 0);
        chk("t7_ovf", 32'(overflow_err), 0);
        idle_in(); tick();
        push(14, 0);
        resolve(0);
        upd("t7_after", 1, 14, 0, 0);
        chk("t7_unf", 32'(underflow_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
